// File: rtl/key_matrix_scanner_if.sv
// Event stream bundle for key_matrix_scanner: byte-wide valid/ready channel
// carrying press/release events from the scanner (master) to its consumer
// (slave).
interface key_matrix_scanner_if;
    logic [7:0] event_tdata;
    logic       event_tvalid;
    logic       event_tready;

    modport master (
        output event_tdata,
        output event_tvalid,
        input  event_tready
    );

    modport slave (
        input  event_tdata,
        input  event_tvalid,
        output event_tready
    );
endinterface

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: 8x8 passive key matrix scanner with per-key debounce,
// a debounced 64-bit key map and a press/release event FIFO.
//
// Build option: define KEY_SCANNER_RELEASE_EVENTS_EN to also emit release
// events. Without it, only presses are pushed. Suppressed releases still
// update key_state and are never counted as drops.
//
// state  | meaning
// -------+------------------------------------------------------------
// SCAN   | current row driven, timer runs to its terminal count, then
//        | the inverted synchronized columns are captured into raw
// UPDATE | one cycle: debounce all 8 keys of the row, flag flips in chg
// EMIT   | eight cycles, one per column: push an event for each flip,
//        | then advance to the next row
module key_matrix_scanner #(
    parameter int SCAN_PERIOD    = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clock,
    input  logic                        aresetn,
    output logic [7:0]                  row_drive,
    input  logic [7:0]                  col_sense,
    output logic [63:0]                 key_state,
    output logic [7:0]                  drop_count,
    key_matrix_scanner_if.master        event_bus
);

    localparam int TW = $clog2(SCAN_PERIOD);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        UPDATE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             row_q, row_d;
    logic [2:0]             col_q, col_d;
    logic [7:0]             raw_q, raw_d;
    logic [7:0]             chg_q, chg_d;
    logic [63:0]            key_state_q, key_state_d;
    logic [63:0][CW-1:0]    deb_q, deb_d;
    logic [7:0]             row_drive_q;
    logic [7:0]             col_meta_q, col_sync_q;

    logic [5:0]             key_idx;
    logic [CW-1:0]          deb_inc;
    logic                   ev_enable;
    logic                   push_req;
    logic [7:0]             push_data;

    logic [FIFO_DEPTH-1:0][7:0] mem_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;
    logic [7:0]             drop_q;
    logic                   pop;
    logic                   push_ok;

    // Release events are only forwarded when the build option enables them;
    // raw[c] is 1 for a press, so it doubles as the press-only filter.
`ifdef KEY_SCANNER_RELEASE_EVENTS_EN
    assign ev_enable = 1'b1;
`else
    assign ev_enable = raw_q[col_q];
`endif

    // Two-flop synchronizer for the asynchronous column inputs (idle = pulled up).
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            col_meta_q <= 8'hFF;
            col_sync_q <= 8'hFF;
        end else begin
            col_meta_q <= col_sense;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan FSM next-state, debounce update and event push request.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        row_d       = row_q;
        col_d       = col_q;
        raw_d       = raw_q;
        chg_d       = chg_q;
        key_state_d = key_state_q;
        deb_d       = deb_q;
        key_idx     = '0;
        deb_inc     = '0;
        push_req    = 1'b0;
        push_data   = '0;

        case (state_q)
            SCAN: begin
                if (timer_q == TIMER_LAST) begin
                    raw_d   = ~col_sync_q;
                    state_d = UPDATE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            UPDATE: begin
                for (int c = 0; c < 8; c++) begin
                    key_idx  = {row_q, 3'(c)};
                    deb_inc  = deb_q[key_idx] + 1'b1;
                    chg_d[c] = 1'b0;
                    if (raw_q[c] == key_state_q[key_idx]) begin
                        deb_d[key_idx] = '0;
                    end else if (deb_inc == DEB_TARGET) begin
                        deb_d[key_idx]       = '0;
                        key_state_d[key_idx] = ~key_state_q[key_idx];
                        chg_d[c]             = 1'b1;
                    end else begin
                        deb_d[key_idx] = deb_inc;
                    end
                end
                col_d   = 3'd0;
                state_d = EMIT;
            end

            EMIT: begin
                if (chg_q[col_q] && ev_enable) begin
                    push_req  = 1'b1;
                    push_data = {raw_q[col_q], 1'b0, row_q, col_q};
                end
                if (col_q == 3'd7) begin
                    col_d   = 3'd0;
                    row_d   = row_q + 3'd1;
                    timer_d = '0;
                    state_d = SCAN;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end

            default: begin
                state_d = SCAN;
                timer_d = '0;
            end
        endcase
    end

    // Scan FSM state, debounce state and registered row drive.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= SCAN;
            timer_q     <= '0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            raw_q       <= '0;
            chg_q       <= '0;
            key_state_q <= '0;
            deb_q       <= '0;
            row_drive_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            row_q       <= row_d;
            col_q       <= col_d;
            raw_q       <= raw_d;
            chg_q       <= chg_d;
            key_state_q <= key_state_d;
            deb_q       <= deb_d;
            // row_d only moves on the EMIT->SCAN edge, so the drive is stable
            // for the whole scan of a row.
            row_drive_q <= ~(8'b1 << row_d);
        end
    end

    // A push into a full FIFO still succeeds when the head leaves that cycle;
    // the freed slot is the one the write pointer already addresses.
    assign pop     = (count_q != '0) && event_bus.event_tready;
    assign push_ok = push_req && ((count_q != FIFO_FULL) || pop);

    // Event FIFO storage, pointers, occupancy and saturating drop counter.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (push_req && !push_ok && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign row_drive              = row_drive_q;
    assign key_state              = key_state_q;
    assign drop_count             = drop_q;
    assign event_bus.event_tvalid = (count_q != '0);
    assign event_bus.event_tdata  = mem_q[rd_ptr_q];

endmodule
